// File: rtl/inst_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
// PC register resets to BOOT_PC so the BOOT step lands on address 0.
package inst_fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP     = 4;

  localparam logic [31:0] BOOT_PC = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IF_BOOT  = 3'd0,
    IF_REQ   = 3'd1,
    IF_WAIT  = 3'd2,
    IF_HOLD  = 3'd3,
    IF_DRAIN = 3'd4
  } if_state_e;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory req/gnt/rvalid bundle.
// master = fetch unit, slave = memory.
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int W = INSTR_WIDTH
) ();

  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_buffer.sv
// Single-entry {pc, instr} holding register for a stalled response.
// clear wins over load.
module if_buffer
  import inst_fetch_pkg::*;
#(
  parameter int W = INSTR_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] instr_in,
  output logic [W-1:0] pc_out,
  output logic [W-1:0] instr_out,
  output logic         valid
);

  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] instr_q, instr_d;
  logic         valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (clear) begin
      pc_d    = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid     = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch FSM: drives PC register, one outstanding imem request,
// delivers {pc, instr} to IF/ID with stall and redirect handling.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int INSTR_WIDTH = inst_fetch_pkg::INSTR_WIDTH,
  parameter int PC_STEP     = inst_fetch_pkg::PC_STEP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] pc,
  output logic                   pc_en,
  output logic [INSTR_WIDTH-1:0] next_pc,
  input  logic                   redirect_valid,
  input  logic [INSTR_WIDTH-1:0] redirect_target,
  input  logic                   id_stall,
  inst_fetch_if.master           imem,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr
);

  localparam int W = INSTR_WIDTH;

  if_state_e state_q, state_d;
  logic [W-1:0] addr_q, addr_d;

  logic         buf_load, buf_clear, buf_valid;
  logic [W-1:0] buf_pc, buf_instr;

  logic         pc_en_c, if_valid_c, req_c;
  logic [W-1:0] next_pc_c, if_pc_c, if_instr_c;
  logic [W-1:0] pc_inc;
  logic         redir;

  assign pc_inc = pc + W'(PC_STEP);
  assign redir  = redirect_valid;

  if_buffer #(.W(W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .pc_in    (addr_q),
    .instr_in (imem.imem_rdata),
    .pc_out   (buf_pc),
    .instr_out(buf_instr),
    .valid    (buf_valid)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pc_en_c    = 1'b0;
    req_c      = 1'b0;
    if_valid_c = 1'b0;
    if_pc_c    = '0;
    if_instr_c = '0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    next_pc_c  = pc_inc;

    unique case (state_q)
      IF_BOOT: begin
        pc_en_c = 1'b1;
        state_d = IF_REQ;
      end
      IF_REQ: begin
        req_c  = 1'b1;
        addr_d = pc;
        if (redir) begin
          pc_en_c = 1'b1;
          state_d = imem.imem_gnt ? IF_DRAIN : IF_REQ;
        end else if (imem.imem_gnt) begin
          state_d = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (redir) begin
          pc_en_c = 1'b1;
          state_d = imem.imem_rvalid ? IF_REQ : IF_DRAIN;
        end else if (imem.imem_rvalid) begin
          if (!id_stall) begin
            if_valid_c = 1'b1;
            if_pc_c    = addr_q;
            if_instr_c = imem.imem_rdata;
            pc_en_c    = 1'b1;
            state_d    = IF_REQ;
          end else begin
            buf_load = 1'b1;
            state_d  = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        if (redir) begin
          pc_en_c   = 1'b1;
          buf_clear = 1'b1;
          state_d   = IF_REQ;
        end else begin
          if_valid_c = buf_valid;
          if_pc_c    = buf_pc;
          if_instr_c = buf_instr;
          if (!id_stall) begin
            pc_en_c   = 1'b1;
            buf_clear = 1'b1;
            state_d   = IF_REQ;
          end
        end
      end
      IF_DRAIN: begin
        // latest redirect wins; the stale response just ends the drain
        if (redir) pc_en_c = 1'b1;
        if (imem.imem_rvalid) state_d = IF_REQ;
      end
      default: state_d = IF_BOOT;
    endcase

    if (redir && state_q != IF_BOOT) next_pc_c = redirect_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IF_BOOT;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    pc_en    = pc_en_c;
    next_pc  = next_pc_c;
    if_valid = if_valid_c;
    if_pc    = if_pc_c;
    if_instr = if_instr_c;
    imem.imem_req = req_c;
    if (rst) begin
      pc_en    = 1'b0;
      next_pc  = '0;
      if_valid = 1'b0;
      if_pc    = '0;
      if_instr = '0;
      imem.imem_req = 1'b0;
    end
  end

  assign imem.imem_addr = pc;

  a_no_unsolicited_rvalid: assert property (
    @(posedge clk) disable iff (rst)
    imem.imem_rvalid |-> (state_q inside {IF_WAIT, IF_DRAIN})
  );

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end that drives the PC register and consumes its value.
- Generates next_pc and pc_en for the PC register.
- Issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Delivers {pc, instr} to the IF/ID pipeline register, honouring ID stalls and EX redirects (branch/jump).

Parameters:
- INSTR_WIDTH, 32, width of PC, addresses and instruction words (matches `INSTR_WIDTH in defines.v)
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- pc  input  INSTR_WIDTH  current PC from PC register
- pc_en  output  1  PC register load enable
- next_pc  output  INSTR_WIDTH  value loaded into PC when pc_en=1
- redirect_valid  input  1  EX branch/jump taken this cycle
- redirect_target  input  INSTR_WIDTH  redirect destination
- id_stall  input  1  IF/ID must not accept a new instruction
- imem_req  output  1  memory request
- imem_addr  output  INSTR_WIDTH  request address (= pc)
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  response data valid (one per granted request, in order, ≥1 cycle after gnt)
- imem_rdata  input  INSTR_WIDTH  response instruction
- if_valid  output  1  instruction presented to IF/ID
- if_pc  output  INSTR_WIDTH  PC of presented instruction
- if_instr  output  INSTR_WIDTH  presented instruction

Behaviour:
- States: BOOT, REQ, WAIT, HOLD, DRAIN. At most one request outstanding.
- Reset (async, rst=1): state=BOOT, buffer cleared, kill=0. While in reset: pc_en=0, imem_req=0, if_valid=0, next_pc=0, if_pc=0, if_instr=0.
- PC register resets to 0xFFFF_FFFC. BOOT asserts pc_en for one cycle with next_pc=pc+PC_STEP, so the first fetch is address 0. Then → REQ.
- next_pc default: pc+PC_STEP, modulo 2^INSTR_WIDTH (wrap, no flag). When redirect_valid=1: next_pc=redirect_target.
- REQ: imem_req=1, imem_addr=pc, latched addr_q=pc.
  - gnt=1 → WAIT.
  - gnt=0 → stay in REQ, request held stable.
- WAIT: imem_req=0. On rvalid:
  - id_stall=0: if_valid=1, if_pc=addr_q, if_instr=imem_rdata (same cycle, zero latency); pc_en=1, next_pc=pc+PC_STEP; → REQ.
  - id_stall=1: capture rdata into buffer; → HOLD.
- HOLD: if_valid=1 from buffer. When id_stall=0: pc_en=1, next_pc=pc+PC_STEP; → REQ.
- Redirect priority (redirect_valid overrides id_stall and normal advance). In every case pc_en=1, next_pc=redirect_target, and if_valid is forced 0 that cycle:
  - BOOT: redirect ignored.
  - REQ, gnt=0: request withdrawn (imem permits withdrawal of ungranted requests); → REQ.
  - REQ, gnt=1: old request is in flight; → DRAIN.
  - WAIT, rvalid=0: → DRAIN.
  - WAIT, rvalid=1: response discarded; → REQ.
  - HOLD: buffer discarded; → REQ.
  - DRAIN: stays DRAIN; pc updated again (latest redirect wins).
- DRAIN: imem_req=0, if_valid=0. On rvalid: response discarded; → REQ.
- pc_en is asserted for exactly one cycle per PC advance; never asserted in REQ, DRAIN or WAIT-without-rvalid unless a redirect occurs.
- Unsolicited rvalid (in REQ, HOLD or BOOT) is a protocol violation: ignored; an assertion flags it in simulation.
- Reset mid-transaction: state returns to BOOT immediately. The memory is reset by the same rst, so no drain is required.

Decomposition:
- Shared package/defines: INSTR_WIDTH, PC_STEP, BOOT_PC (0xFFFF_FFFC), FSM state encodings (IF_BOOT … IF_DRAIN).
- One natural sub-module: if_buffer. Single-entry {pc, instr} holding register with load/clear, used by HOLD.
- FSM and next_pc mux stay in inst_fetch.

Test Plan:
- Reset release, imem gnt same cycle, rvalid next cycle, no stalls → pc_en in BOOT cycle; if_pc sequence 0x0, 0x4, 0x8 with matching rdata; each if_valid one cycle, 2 cycles apart.
- Stall: rvalid for pc=0x8 with id_stall=1 for 3 cycles → if_valid held 3 cycles with pc 0x8 and same instr; pc_en only in the cycle id_stall falls; next fetch 0xC.
- Redirect in WAIT before rvalid, target 0x100 → pc_en with next_pc=0x100; late response for the old pc dropped (if_valid=0); next imem_addr=0x100.
- Redirect coincident with gnt in REQ, then a second redirect to 0x200 during DRAIN → one response discarded; next request addr 0x200.
- Wrap: redirect to 0xFFFF_FFFC, normal fetch → next_pc=0x0000_0000 after it is delivered.
- Async rst asserted while in WAIT → outputs zero immediately; after release, fetch restarts at 0x0.
